// File: rtl/ftdi_pkg.sv
// Shared constants for the FTDI command path: byte width, the filler byte
// returned for out-of-range reads, command header bit position and the
// default response FIFO depth.
package ftdi_pkg;

  localparam int unsigned       BYTE_W             = 8;
  localparam logic [BYTE_W-1:0] READ_INVALID       = 8'hEE;
  localparam int unsigned       HDR_WRITE_BIT      = 0;
  localparam int unsigned       FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO, first-word-fall-through: dout always shows the
// head entry. A push while full is accepted only if a pop happens at the
// same edge. Pops while empty are ignored. DEPTH must be a power of two.
module sync_byte_fifo
  import ftdi_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // The slot freed by a same-edge pop makes room for the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy, wrapping naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ftdi_reg_bank.sv
// Register bank behind the FTDI command decoder. Decoded writes update a
// byte-wide register file; decoded reads queue one byte each into a response
// FIFO that drains into the FTDI TX FIFO under tx_full.
// Optional feature macro: ADDR_AUTOINC_EN (bursts walk consecutive addresses).
module ftdi_reg_bank
  import ftdi_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic [ADDR_W-1:0]             cmd_address,
  input  logic [BYTE_W-1:0]             cmd_value,
  input  logic                          cmd_write,
  input  logic                          cmd_read,
  output logic [BYTE_W-1:0]             tx_data,
  output logic                          tx_write,
  input  logic                          tx_full,
  output logic [NUM_REGS*BYTE_W-1:0]    reg_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic [BYTE_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] ea;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [BYTE_W-1:0] rd_byte;
  logic              fifo_empty;
  logic              fifo_full;

`ifdef ADDR_AUTOINC_EN
  logic [ADDR_W-1:0] offset;

  // Burst offset: advances on every command cycle, clears on an idle cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      offset <= '0;
    end else if (cmd_write || cmd_read) begin
      offset <= offset + 1'b1;
    end else begin
      offset <= '0;
    end
  end

  assign ea = cmd_address + offset;
`else
  assign ea = cmd_address;
`endif

  assign in_range = (32'(ea) < NUM_REGS);
  assign idx      = ea[IDX_W-1:0];
  // Read mux sees the pre-write register value on a same-cycle write.
  assign rd_byte  = in_range ? regs[idx] : READ_INVALID;

  // Register file: in-range writes land at the next edge.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (cmd_write && in_range) begin
      regs[idx] <= cmd_value;
    end
  end

  // Flatten the register file for observation.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[BYTE_W*i +: BYTE_W] = regs[i];
    end
  end

  assign tx_write = !fifo_empty && !tx_full && !res;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .res   (res),
    .push  (cmd_read),
    .pop   (tx_write),
    .din   (rd_byte),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Sticky drop flag: a read arrived while full with no room freed.
  always_ff @(posedge clk) begin
    if (res) begin
      overflow <= 1'b0;
    end else if (cmd_read && fifo_full && !tx_write) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftdi_reg_bank.sv
// Scoreboarded bench for ftdi_reg_bank with directed command vectors.
module tb_ftdi_reg_bank;

`ifdef ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         res;
  logic [7:0]   cmd_address;
  logic [7:0]   cmd_value;
  logic         cmd_write;
  logic         cmd_read;
  logic [7:0]   tx_data;
  logic         tx_write;
  logic         tx_full;
  logic [127:0] reg_out;
  logic [4:0]   fifo_level;
  logic         overflow;

  ftdi_reg_bank #(
    .NUM_REGS   (16),
    .ADDR_W     (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .res         (res),
    .cmd_address (cmd_address),
    .cmd_value   (cmd_value),
    .cmd_write   (cmd_write),
    .cmd_read    (cmd_read),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .tx_full     (tx_full),
    .reg_out     (reg_out),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_popped = 0;
  logic [7:0] model [16];
  logic [7:0] sb [$];

  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    return (a < 8'd16) ? model[a[3:0]] : 8'hEE;
  endfunction

  function automatic logic [127:0] exp_regs();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = model[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every byte handed to the TX FIFO must match the scoreboard head.
  always @(negedge clk) begin
    if (tx_write === 1'b1) begin
      n_checks++;
      n_popped++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
        end
      end
    end
  end

  // Issue n back-to-back command cycles, then one idle cycle. Only the first
  // n_keep read responses are expected to survive.
  task automatic cmd(input bit wr, input bit rd, input logic [7:0] a,
                     input logic [7:0] v, input int n, input int n_keep);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = AUTOINC ? a + 8'(i) : a;
      if (rd && i < n_keep) sb.push_back(exp_byte(e));
      if (wr && e < 8'd16) model[e[3:0]] = v;
      cmd_address = a;
      cmd_value   = v;
      cmd_write   = wr;
      cmd_read    = rd;
      @(posedge clk); #1;
    end
    cmd_write = 1'b0;
    cmd_read  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((fifo_level != 0 || sb.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_drain_pending"}, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    res = 1'b1; tx_full = 1'b0;
    cmd_address = '0; cmd_value = '0; cmd_write = 1'b0; cmd_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("rst_level", 128'(fifo_level), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_regs", reg_out, 128'd0);
    chk("rst_tx_write", 128'(tx_write), 128'd0);
    @(posedge clk); #1;

    // 1: write then read back
    cmd(1'b1, 1'b0, 8'd3, 8'h5A, 1, 0);
    chk("t1_regs", reg_out, exp_regs());
    cmd(1'b0, 1'b1, 8'd3, 8'h00, 1, 1);
    wait_drain("t1", 20);

    // 2: out-of-range read and write
    cmd(1'b0, 1'b1, 8'h40, 8'h00, 1, 1);
    cmd(1'b1, 1'b0, 8'h40, 8'h99, 1, 0);
    chk("t2_regs_unchanged", reg_out, exp_regs());
    wait_drain("t2", 20);

    // 3: overflow under backpressure, then ordered drain
    tx_full = 1'b1;
    cmd(1'b0, 1'b1, 8'd3, 8'h00, 20, 16);
    chk("t3_level_full", 128'(fifo_level), 128'd16);
    chk("t3_overflow", 128'(overflow), 128'd1);
    p0 = n_popped;
    tx_full = 1'b0;
    wait_drain("t3", 60);
    chk("t3_pop_count", 128'(n_popped - p0), 128'd16);
    chk("t3_overflow_sticky", 128'(overflow), 128'd1);

    // 4: same-cycle write and read returns pre-write value
    cmd(1'b1, 1'b0, 8'd2, 8'h77, 1, 0);
    cmd(1'b1, 1'b1, 8'd2, 8'h11, 1, 1);
    wait_drain("t4", 20);
    chk("t4_regs", reg_out, exp_regs());

    // 5: reset with bytes queued
    tx_full = 1'b1;
    cmd(1'b0, 1'b1, 8'd5, 8'h00, 5, 0);
    chk("t5_level_before", 128'(fifo_level), 128'd5);
    res = 1'b1;
    tx_full = 1'b0;
    @(negedge clk);
    chk("t5_tx_write_in_reset", 128'(tx_write), 128'd0);
    @(posedge clk); #1;
    res = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("t5_level", 128'(fifo_level), 128'd0);
    chk("t5_overflow", 128'(overflow), 128'd0);
    chk("t5_regs", reg_out, 128'd0);

    // 6: read burst at the top of the register file
    cmd(1'b1, 1'b0, 8'd14, 8'hA1, 1, 0);
    cmd(1'b1, 1'b0, 8'd15, 8'hB2, 1, 0);
    cmd(1'b0, 1'b1, 8'd14, 8'h00, 4, 4);
    wait_drain("t6", 30);
    chk("t6_regs", reg_out, exp_regs());
    chk("final_level", 128'(fifo_level), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
